// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the note-button input stage.
// Contents: FSM state encoding, button/note widths, and the helpers that
// turn a debounced button vector into a note index and a multi-press flag.
package detector_jogada_pkg;

   localparam int NUM_BOTOES = 12;
   localparam int NOTA_WIDTH = 4;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESPERA   = 2'd1,
      CONTANDO = 2'd2,
      EMITE    = 2'd3
   } estado_t;

   // Priority encoder: index of the lowest set bit (0 when the vector is empty).
   function automatic logic [NOTA_WIDTH-1:0] menor_indice(input logic [NUM_BOTOES-1:0] vetor);
      logic [NOTA_WIDTH-1:0] idx;
      idx = '0;
      for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
         if (vetor[i]) begin
            idx = NOTA_WIDTH'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves something only when two or more were set.
   function automatic logic mais_de_um(input logic [NUM_BOTOES-1:0] vetor);
      return (vetor & (vetor - NUM_BOTOES'(1))) != '0;
   endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Event bus from the input stage to the game FSM / tempo comparator.
// Signals: jogada_valida (press-complete pulse), nota, duracao, multiplos
// (held until the next event), timeout (pulse), pressionado (level).
// master = producer (detector_jogada), slave = consumer.
interface detector_jogada_if #(
   parameter int DUR_WIDTH = 16
);
   import detector_jogada_pkg::*;

   logic                  jogada_valida;
   logic [NOTA_WIDTH-1:0] nota;
   logic [DUR_WIDTH-1:0]  duracao;
   logic                  multiplos;
   logic                  timeout;
   logic                  pressionado;

   modport master (
      output jogada_valida, nota, duracao, multiplos, timeout, pressionado
   );

   modport slave (
      input  jogada_valida, nota, duracao, multiplos, timeout, pressionado
   );

endinterface

// File: rtl/detector_jogada_debounce_botoes.sv
// Two-flop synchronizer plus whole-vector stability filter.
// Ports: clock, reset (async, active-low), botoes (raw, asynchronous),
// deb (debounced vector). A new value reaches deb after the synchronized
// vector has held it for DEBOUNCE_CYCLES cycles; press and release see the
// same latency, so measured hold times are not skewed.
module debounce_botoes
   import detector_jogada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_BOTOES-1:0] botoes,
   output logic [NUM_BOTOES-1:0] deb
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [NUM_BOTOES-1:0] sync1_r;
   logic [NUM_BOTOES-1:0] sync2_r;
   logic [NUM_BOTOES-1:0] cand_r;
   logic [NUM_BOTOES-1:0] deb_r;
   logic [CW-1:0]         cnt_r;

   // Synchronize the raw buttons and accept a candidate only after it is stable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
         cand_r  <= '0;
         deb_r   <= '0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= botoes;
         sync2_r <= sync1_r;
         if (sync2_r == deb_r) begin
            // Nothing pending; re-arm so any new value starts a fresh count.
            cand_r <= deb_r;
            cnt_r  <= '0;
         end else if (sync2_r != cand_r) begin
            cand_r <= sync2_r;
            cnt_r  <= '0;
         end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_r <= sync2_r;
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign deb = deb_r;

endmodule

// File: rtl/detector_jogada.sv
// Note-button input stage: debounces the 12 buttons, encodes the pressed
// note, measures hold time in cycles and reports press-complete / timeout
// events to the game logic.
// Ports: clock, reset (async, active-low), habilita (player's turn),
// botoes (raw buttons), saida (event bus, master side).
// Optional feature: define DETECTOR_TIMEOUT_EN to build the wait-for-press
// timeout; without it timeout is tied low and ESPERA waits indefinitely.
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int CLOCK_FREQ      = 5000,
   parameter int DEBOUNCE_CYCLES = 50,
   parameter int DUR_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES  = 25000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  habilita,
   input  logic [NUM_BOTOES-1:0] botoes,
   detector_jogada_if.master     saida
);

   // All timing is in cycles; CLOCK_FREQ only documents the intended rate.
   if (CLOCK_FREQ < 1 || DEBOUNCE_CYCLES < 1 || DUR_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_invalid
      $error("detector_jogada: invalid parameter value");
   end

   logic [NUM_BOTOES-1:0] deb_s;
   logic [NUM_BOTOES-1:0] deb_ant_r;
   estado_t               estado_r;
   logic                  hab_r;
   logic [DUR_WIDTH-1:0]  dur_cnt_r;
   logic [NOTA_WIDTH-1:0] nota_lat_r;
   logic                  mult_lat_r;
   logic                  jogada_valida_r;
   logic [NOTA_WIDTH-1:0] nota_r;
   logic [DUR_WIDTH-1:0]  duracao_r;
   logic                  multiplos_r;
   logic                  pressionado_r;
`ifdef DETECTOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]         tmo_cnt_r;
   logic                  timeout_r;
`endif

   debounce_botoes #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock (clock),
      .reset (reset),
      .botoes(botoes),
      .deb   (deb_s)
   );

   // Press FSM. Note/multi flags are latched privately and copied to the
   // outputs only in EMITE, so an aborted press leaves the outputs untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_r        <= OCIOSO;
         hab_r           <= 1'b0;
         deb_ant_r       <= '0;
         dur_cnt_r       <= '0;
         nota_lat_r      <= '0;
         mult_lat_r      <= 1'b0;
         jogada_valida_r <= 1'b0;
         nota_r          <= '0;
         duracao_r       <= '0;
         multiplos_r     <= 1'b0;
         pressionado_r   <= 1'b0;
`ifdef DETECTOR_TIMEOUT_EN
         tmo_cnt_r       <= '0;
         timeout_r       <= 1'b0;
`endif
      end else begin
         hab_r           <= habilita;
         deb_ant_r       <= deb_s;
         jogada_valida_r <= 1'b0;
`ifdef DETECTOR_TIMEOUT_EN
         timeout_r       <= 1'b0;
`endif
         case (estado_r)
            OCIOSO: begin
               if (habilita && !hab_r) begin
                  estado_r <= ESPERA;
`ifdef DETECTOR_TIMEOUT_EN
                  tmo_cnt_r <= '0;
`endif
               end else begin
                  estado_r <= OCIOSO;
               end
            end
            ESPERA: begin
               // Abort beats press, and press beats a timeout in the same cycle.
               if (!habilita) begin
                  estado_r <= OCIOSO;
               end else if (deb_s != '0) begin
                  dur_cnt_r     <= DUR_WIDTH'(1);
                  nota_lat_r    <= menor_indice(deb_s);
                  mult_lat_r    <= mais_de_um(deb_s);
                  pressionado_r <= 1'b1;
                  estado_r      <= CONTANDO;
`ifdef DETECTOR_TIMEOUT_EN
               end else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_r <= 1'b1;
                  estado_r  <= OCIOSO;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
`else
               end else begin
                  estado_r <= ESPERA;
               end
`endif
            end
            CONTANDO: begin
               if (!habilita) begin
                  pressionado_r <= 1'b0;
                  estado_r      <= OCIOSO;
               end else if (deb_s == '0) begin
                  pressionado_r <= 1'b0;
                  estado_r      <= EMITE;
               end else begin
                  if (dur_cnt_r != '1) begin
                     dur_cnt_r <= dur_cnt_r + DUR_WIDTH'(1);
                  end else begin
                     dur_cnt_r <= dur_cnt_r;
                  end
                  if (deb_s != deb_ant_r) begin
                     mult_lat_r <= 1'b1;
                  end else begin
                     mult_lat_r <= mult_lat_r;
                  end
               end
            end
            EMITE: begin
               jogada_valida_r <= 1'b1;
               nota_r          <= nota_lat_r;
               duracao_r       <= dur_cnt_r;
               multiplos_r     <= mult_lat_r;
               if (habilita) begin
                  estado_r <= ESPERA;
`ifdef DETECTOR_TIMEOUT_EN
                  tmo_cnt_r <= '0;
`endif
               end else begin
                  estado_r <= OCIOSO;
               end
            end
            default: begin
               estado_r <= OCIOSO;
            end
         endcase
      end
   end

   assign saida.jogada_valida = jogada_valida_r;
   assign saida.nota          = nota_r;
   assign saida.duracao       = duracao_r;
   assign saida.multiplos     = multiplos_r;
   assign saida.pressionado   = pressionado_r;
`ifdef DETECTOR_TIMEOUT_EN
   assign saida.timeout       = timeout_r;
`else
   assign saida.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: stimulus pushes expected events,
// a negedge monitor pops and compares whenever an event appears.
module tb_detector_jogada;
   import detector_jogada_pkg::*;

   localparam int DEB = 50;
   localparam int DW  = 16;
   localparam int TMO = 25000;
   localparam int LAT = DEB + 2;

   typedef struct {
      logic [3:0] nota;
      int         dur;
      logic       mult;
   } evento_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        habilita;
   logic [11:0] botoes;

   evento_t exp_q[$];
   evento_t ultimo;
   int      tmo_exp = 0;
   int      tmo_at  = 0;
   int      cyc     = 0;
   int      checks  = 0;
   int      errors  = 0;
   logic    saw_press = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   detector_jogada_if #(.DUR_WIDTH(DW)) bus ();

   detector_jogada #(
      .CLOCK_FREQ     (5000),
      .DEBOUNCE_CYCLES(DEB),
      .DUR_WIDTH      (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .habilita(habilita),
      .botoes  (botoes),
      .saida   (bus)
   );

   task automatic check(input string nome, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nome, got, expv);
      end
   endtask

   task automatic check_dur(input string nome, input int got, input int expv);
      checks++;
      if (got > expv + 1 || got + 1 < expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (+-1)", nome, got, expv);
      end
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic espera_evento(input int nota, input int dur, input logic mult);
      evento_t e;
      e.nota = 4'(nota);
      e.dur  = dur;
      e.mult = mult;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string nome, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || tmo_exp != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || tmo_exp != 0) begin
         errors++;
         $display("FAIL %s: %0d events pending after %0d cycles, expected 0",
                  nome, exp_q.size() + tmo_exp, budget);
         exp_q.delete();
         tmo_exp = 0;
      end
   endtask

   // Monitor: every event the DUT presents must match the scoreboard head.
   always @(negedge clock) begin : monitor
      evento_t e;
      if (bus.pressionado) saw_press = 1'b1;
      if (bus.jogada_valida) begin
         if (exp_q.size() == 0) begin
            check("unexpected_jogada", 1, 0);
         end else begin
            e = exp_q.pop_front();
            ultimo = e;
            check("nota", int'(bus.nota), int'(e.nota));
            check_dur("duracao", int'(bus.duracao), e.dur);
            check("multiplos", int'(bus.multiplos), int'(e.mult));
         end
      end
      if (bus.timeout) begin
         tmo_at = cyc;
         if (tmo_exp == 0) begin
            check("unexpected_timeout", 1, 0);
         end else begin
            tmo_exp--;
         end
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int start;
      reset    = 1'b0;
      habilita = 1'b0;
      botoes   = '0;
      #12;
      check("reset_jogada_valida", int'(bus.jogada_valida), 0);
      check("reset_nota", int'(bus.nota), 0);
      check("reset_duracao", int'(bus.duracao), 0);
      check("reset_multiplos", int'(bus.multiplos), 0);
      check("reset_timeout", int'(bus.timeout), 0);
      check("reset_pressionado", int'(bus.pressionado), 0);
      @(negedge clock);
      reset = 1'b1;
      ciclos(3);

      // 1: single note 2, 7500 cycles
      habilita = 1'b1;
      ciclos(10);
      espera_evento(2, 7500, 1'b0);
      botoes = 12'b000000000100;
      ciclos(1000);
      check("pressionado_during_press", int'(bus.pressionado), 1);
      ciclos(6500);
      botoes = '0;
      wait_drain("t1_drain", 200);

      // 2: short glitch ignored, then real hold of note 4
      saw_press = 1'b0;
      botoes = 12'b000000010000;
      ciclos(20);
      botoes = '0;
      ciclos(150);
      check("glitch_no_pressionado", int'(saw_press), 0);
      espera_evento(4, 10000, 1'b0);
      botoes = 12'b000000010000;
      ciclos(10000);
      botoes = '0;
      wait_drain("t2_drain", 200);

      // 4: two buttons together -> lowest index, multiplos
      espera_evento(2, 3000, 1'b1);
      botoes = 12'b000000001100;
      ciclos(3000);
      botoes = '0;
      wait_drain("t4_drain", 200);

      // second button added mid-press -> multiplos set, note latched at start
      espera_evento(0, 1000, 1'b1);
      botoes = 12'b000000000001;
      ciclos(500);
      botoes = 12'b000000000011;
      ciclos(500);
      botoes = '0;
      wait_drain("t4b_drain", 200);

      // 5: habilita dropped mid-press -> no event, outputs held
      botoes = 12'b000010000000;
      ciclos(1000);
      check("t5_pressionado_before_drop", int'(bus.pressionado), 1);
      habilita = 1'b0;
      ciclos(5);
      check("t5_pressionado_after_drop", int'(bus.pressionado), 0);
      check("t5_nota_held", int'(bus.nota), int'(ultimo.nota));
      check_dur("t5_duracao_held", int'(bus.duracao), ultimo.dur);
      check("t5_multiplos_held", int'(bus.multiplos), int'(ultimo.mult));
      botoes = '0;
      ciclos(200);

      // 6: reset mid-press, then press measured from ESPERA entry
      habilita = 1'b1;
      botoes = 12'b001000000000;
      ciclos(500);
      check("t6_pressionado_before_reset", int'(bus.pressionado), 1);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_nota", int'(bus.nota), 0);
      check("t6_rst_duracao", int'(bus.duracao), 0);
      check("t6_rst_multiplos", int'(bus.multiplos), 0);
      check("t6_rst_pressionado", int'(bus.pressionado), 0);
      habilita = 1'b0;
      ciclos(5);
      reset = 1'b1;
      saw_press = 1'b0;
      ciclos(200);
      check("t6_ignored_while_disabled", int'(saw_press), 0);
      espera_evento(9, 1500 + LAT, 1'b0);
      habilita = 1'b1;
      ciclos(1500);
      botoes = '0;
      wait_drain("t6_drain", 200);

      // 3: timeout window measured from a fresh habilita rise
      habilita = 1'b0;
      ciclos(5);
      start = cyc;
      habilita = 1'b1;
`ifdef DETECTOR_TIMEOUT_EN
      tmo_exp = 1;
      wait_drain("t3_timeout", TMO + 100);
      check("t3_timeout_cycle", tmo_at - start, TMO + 1);
      ciclos(2000);
      saw_press = 1'b0;
      botoes = 12'b000000000001;
      ciclos(300);
      botoes = '0;
      ciclos(200);
      check("t3_idle_after_timeout", int'(saw_press), 0);
`else
      ciclos(3000);
      check("t3_no_timeout_count", tmo_at, 0);
      espera_evento(0, 300, 1'b0);
      botoes = 12'b000000000001;
      ciclos(300);
      botoes = '0;
      wait_drain("t3_press_after_wait", 200);
`endif

      check("leftover_events", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
